// File: rtl/rule_circuit_pipe.sv
// rule_circuit_pipe: programmable per-output product-term rules behind a 1-deep registered valid/ready stage.
module rule_circuit_pipe #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 5,
  parameter int CNT_W = 16,
  localparam int AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_mask,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [1:0]       cfg_mode,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [CNT_W-1:0] sample_cnt
);
  logic [N_IN-1:0]  r_mask [N_OUT];
  logic [N_IN-1:0]  r_val  [N_OUT];
  logic [1:0]       r_mode [N_OUT];
  logic [N_OUT-1:0] w_term;
  logic [N_OUT-1:0] w_eval;
  logic             w_acc;
  logic             w_addr_ok;
  assign in_ready  = ~out_valid | out_ready;
  assign w_acc     = in_valid & in_ready;
  assign w_addr_ok = int'(cfg_addr) < N_OUT;
  for (genvar j = 0; j < N_OUT; j++) begin : g_rule
    assign w_term[j] = &(~r_mask[j] | ~(in_data ^ r_val[j]));
    assign w_eval[j] = r_mode[j][1] ? (w_term[j] ^ r_mode[j][0]) : r_mode[j][0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_mask[j] <= '0;
        r_val[j]  <= '0;
        r_mode[j] <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      sample_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      // the accepted sample is evaluated with the rules as they stood before this edge
      if (cfg_we && w_addr_ok) begin
        r_mask[cfg_addr] <= cfg_mask;
        r_val[cfg_addr]  <= cfg_val;
        r_mode[cfg_addr] <= cfg_mode;
      end
      cfg_err    <= cfg_we & ~w_addr_ok;
      out_valid  <= w_acc ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      out_data   <= w_acc ? w_eval : out_data;
      sample_cnt <= (w_acc && !(&sample_cnt)) ? sample_cnt + CNT_W'(1) : sample_cnt;
    end
  end
endmodule

// File: tb/tb_rule_circuit_pipe.sv
// tb_rule_circuit_pipe: table vectors, directed corner sequences and random traffic against a rule-level model.
module tb_rule_circuit_pipe;
  typedef struct {
    logic [4:0] din;
    logic [4:0] exp;
  } vec_t;
  logic        clk = 0, rst_n = 0, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [2:0]  cfg_addr = 0;
  logic [4:0]  cfg_mask = 0, cfg_val = 0, in_data = 0;
  logic [1:0]  cfg_mode = 0;
  logic        cfg_err, in_ready, out_valid;
  logic [4:0]  out_data;
  logic [15:0] sample_cnt;
  logic        s_err, s_ready, s_valid;
  logic [4:0]  s_data;
  logic [1:0]  s_cnt;
  logic [4:0]  m_mask [5];
  logic [4:0]  m_val  [5];
  logic [1:0]  m_mode [5];
  logic        m_valid = 0, m_err = 0;
  logic [4:0]  m_data = 0;
  int          m_total = 0;
  int          n_tests = 0, n_fail = 0;
  vec_t        tbl [32];
  always #5 clk = ~clk;
  rule_circuit_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_val(cfg_val), .cfg_mode(cfg_mode), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sample_cnt(sample_cnt));
  rule_circuit_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_val(cfg_val), .cfg_mode(cfg_mode), .cfg_err(s_err), .in_valid(in_valid),
    .in_ready(s_ready), .in_data(in_data), .out_valid(s_valid), .out_ready(out_ready),
    .out_data(s_data), .sample_cnt(s_cnt));
  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] model_eval(logic [4:0] x);
    logic [4:0] r;
    logic t;
    r = '0;
    for (int j = 0; j < 5; j++) begin
      t = ((x ^ m_val[j]) & m_mask[j]) == 5'd0;
      case (m_mode[j])
        2'd0: r[j] = 1'b0;
        2'd1: r[j] = 1'b1;
        2'd2: r[j] = t;
        default: r[j] = !t;
      endcase
    end
    return r;
  endfunction
  task automatic model_reset();
    for (int j = 0; j < 5; j++) begin
      m_mask[j] = 0;
      m_val[j]  = 0;
      m_mode[j] = 0;
    end
    m_valid = 0;
    m_err   = 0;
    m_data  = 0;
    m_total = 0;
  endtask
  task automatic tick();
    logic acc, nv, ne;
    logic [4:0] nd;
    acc = in_valid && (!m_valid || out_ready);
    nd  = acc ? model_eval(in_data) : m_data;
    nv  = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    ne  = cfg_we && cfg_addr >= 3'd5;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      m_data  = nd;
      m_valid = nv;
      m_err   = ne;
      if (acc) m_total++;
      if (cfg_we && cfg_addr < 3'd5) begin
        m_mask[cfg_addr] = cfg_mask;
        m_val[cfg_addr]  = cfg_val;
        m_mode[cfg_addr] = cfg_mode;
      end
    end
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_data", int'(out_data), int'(m_data));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
    chk("sample_cnt", int'(sample_cnt), m_total > 65535 ? 65535 : m_total);
    chk("sat_cnt", int'(s_cnt), m_total > 3 ? 3 : m_total);
    chk("sat_data", int'(s_data), int'(m_data));
  endtask
  task automatic wr(logic [2:0] a, logic [4:0] mk, logic [4:0] v, logic [1:0] md);
    cfg_we = 1; cfg_addr = a; cfg_mask = mk; cfg_val = v; cfg_mode = md;
    tick();
    cfg_we = 0;
  endtask
  initial begin
    logic [4:0] x, held;
    int cnt0;
    for (int i = 0; i < 32; i++) begin
      x = 5'(i);
      tbl[i].din = x;
      tbl[i].exp = {1'b0, ~x[2], x[2] & x[4], 1'b1, ~x[2] & ~x[4]};
    end
    model_reset();
    tick();
    tick();
    rst_n = 1;
    out_ready = 1; in_valid = 1; in_data = 5'b10110;
    tick();
    chk("first_valid", int'(out_valid), 1);
    chk("first_data", int'(out_data), 0);
    chk("first_cnt", int'(sample_cnt), 1);
    in_valid = 0;
    tick();
    wr(0, 5'b10100, 5'b00000, 2'b10);
    wr(1, 5'b00000, 5'b00000, 2'b01);
    wr(2, 5'b10100, 5'b10100, 2'b10);
    wr(3, 5'b00100, 5'b00000, 2'b10);
    wr(4, 5'b00000, 5'b00000, 2'b00);
    for (int i = 0; i < 32; i++) begin
      in_valid = 1; in_data = tbl[i].din;
      tick();
      chk("legacy", int'(out_data), int'(tbl[i].exp));
    end
    in_valid = 0;
    tick();
    in_valid = 1; in_data = 5'd3;
    tick();
    held = out_data;
    cnt0 = int'(sample_cnt);
    out_ready = 0; in_data = 5'd7;
    repeat (3) begin
      tick();
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_hold", int'(out_data), int'(tbl[3].exp));
      chk("bp_cnt", int'(sample_cnt), cnt0);
    end
    out_ready = 1;
    for (int i = 8; i < 12; i++) begin
      tick();
      in_data = 5'(i);
    end
    in_valid = 0;
    tick();
    tick();
    in_valid = 1; in_data = 5'b00000;
    cfg_we = 1; cfg_addr = 3; cfg_mask = 5'b00100; cfg_val = 0; cfg_mode = 2'b11;
    tick();
    cfg_we = 0;
    chk("same_cycle_old_rule", int'(out_data[3]), 1);
    tick();
    chk("next_new_rule", int'(out_data[3]), 0);
    in_valid = 0;
    tick();
    cfg_we = 1; cfg_addr = 6; cfg_mask = 5'b11111; cfg_val = 5'b11111; cfg_mode = 2'b01;
    tick();
    cfg_we = 0;
    chk("bad_addr_err", int'(cfg_err), 1);
    tick();
    chk("bad_addr_pulse", int'(cfg_err), 0);
    in_valid = 1; in_data = 5'b00000;
    tick();
    chk("bad_addr_rules", int'(out_data), 5'b00011);
    in_valid = 0;
    tick();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data   = 5'($urandom);
      cfg_we    = $urandom_range(0, 7) == 0;
      cfg_addr  = 3'($urandom);
      cfg_mask  = 5'($urandom);
      cfg_val   = 5'($urandom);
      cfg_mode  = 2'($urandom);
      tick();
    end
    rst_n = 0; cfg_we = 0; in_valid = 0; out_ready = 1;
    tick();
    rst_n = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 5'(i);
      tick();
    end
    chk("sat_five", int'(s_cnt), 3);
    out_ready = 0;
    tick();
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 0;
    tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    rst_n = 1; out_ready = 1; in_data = 5'b11111;
    tick();
    chk("rst_rules_const0", int'(out_data), 0);
    in_valid = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
